// File: rtl/soc_addr_map_unit_if.sv
// Bus bundle for the programmable address-map unit: rule configuration port,
// lookup request handshake, lookup result handshake and the miss counter.
interface soc_addr_map_unit_if #(
    parameter int NumRules  = 10,
    parameter int NumSlaves = 10,
    parameter int AddrWidth = 64,
    parameter int CntWidth  = 16
);
    localparam int RW   = (NumRules > 1) ? $clog2(NumRules) : 1;
    localparam int IdxW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

    logic                 cfg_we;
    logic [RW-1:0]        cfg_rule;
    logic [AddrWidth-1:0] cfg_base;
    logic [AddrWidth-1:0] cfg_len;
    logic [IdxW-1:0]      cfg_idx;
    logic                 cfg_en;
    logic                 cfg_lock;
    logic                 cfg_err;

    logic                 req_valid;
    logic                 req_ready;
    logic [AddrWidth-1:0] req_addr;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [AddrWidth-1:0] resp_addr;
    logic [IdxW-1:0]      resp_idx;
    logic                 resp_hit;

    logic [CntWidth-1:0]  miss_cnt;

    modport master (
        output cfg_we, cfg_rule, cfg_base, cfg_len, cfg_idx, cfg_en, cfg_lock,
        output req_valid, req_addr, resp_ready,
        input  cfg_err, req_ready, resp_valid, resp_addr, resp_idx, resp_hit, miss_cnt
    );

    modport slave (
        input  cfg_we, cfg_rule, cfg_base, cfg_len, cfg_idx, cfg_en, cfg_lock,
        input  req_valid, req_addr, resp_ready,
        output cfg_err, req_ready, resp_valid, resp_addr, resp_idx, resp_hit, miss_cnt
    );
endinterface

// File: rtl/soc_addr_map_unit.sv
// Runtime-programmable address map: lowest-numbered enabled rule covering the
// address selects the slave; result is registered one cycle after acceptance.
module soc_addr_map_unit #(
    parameter int NumRules   = 10,
    parameter int NumSlaves  = 10,
    parameter int AddrWidth  = 64,
    parameter int DefaultIdx = 0,
    parameter int CntWidth   = 16
) (
    input logic              clk,
    input logic              rst_n,
    soc_addr_map_unit_if.slave bus
);
    localparam int RW   = (NumRules > 1) ? $clog2(NumRules) : 1;
    localparam int IdxW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

    logic [AddrWidth-1:0] rule_base [NumRules];
    logic [AddrWidth-1:0] rule_len  [NumRules];
    logic [IdxW-1:0]      rule_idx  [NumRules];
    logic [NumRules-1:0]  rule_en;
    logic [NumRules-1:0]  rule_lock;

    logic            rule_in_range;
    logic            rule_locked;
    logic            wr_ok;
    logic            lookup_hit;
    logic [IdxW-1:0] lookup_idx;
    logic            req_fire;

    always_comb begin
        rule_locked = 1'b0;
        for (int r = 0; r < NumRules; r++) begin
            if (bus.cfg_rule == RW'(r)) begin
                rule_locked = rule_lock[r];
            end
        end
        rule_in_range = {1'b0, bus.cfg_rule} < (RW + 1)'(NumRules);
        wr_ok         = bus.cfg_we && rule_in_range && !rule_locked;
    end

    // Descending scan so the lowest matching rule number overrides the rest.
    // The difference form keeps regions that run past the top of the space legal.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_idx = IdxW'(DefaultIdx);
        for (int r = NumRules - 1; r >= 0; r--) begin
            if (rule_en[r] && (rule_len[r] != '0) && (bus.req_addr >= rule_base[r]) &&
                ((bus.req_addr - rule_base[r]) < rule_len[r])) begin
                lookup_hit = 1'b1;
                lookup_idx = rule_idx[r];
            end
        end
    end

    assign bus.req_ready = !bus.resp_valid || bus.resp_ready;
    assign req_fire      = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NumRules; r++) begin
                rule_base[r] <= '0;
                rule_len[r]  <= '0;
                rule_idx[r]  <= '0;
            end
            rule_en     <= '0;
            rule_lock   <= '0;
            bus.cfg_err <= 1'b0;
        end else begin
            bus.cfg_err <= bus.cfg_we && !wr_ok;
            for (int r = 0; r < NumRules; r++) begin
                if (wr_ok && (bus.cfg_rule == RW'(r))) begin
                    rule_base[r] <= bus.cfg_base;
                    rule_len[r]  <= bus.cfg_len;
                    rule_idx[r]  <= bus.cfg_idx;
                    rule_en[r]   <= bus.cfg_en;
                    rule_lock[r] <= bus.cfg_lock;
                end
            end
        end
    end

    // Result fields only move on acceptance so they stay stable under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid <= 1'b0;
            bus.resp_addr  <= '0;
            bus.resp_idx   <= '0;
            bus.resp_hit   <= 1'b0;
            bus.miss_cnt   <= '0;
        end else begin
            if (req_fire) begin
                bus.resp_valid <= 1'b1;
                bus.resp_addr  <= bus.req_addr;
                bus.resp_idx   <= lookup_idx;
                bus.resp_hit   <= lookup_hit;
                if (!lookup_hit && (bus.miss_cnt != '1)) begin
                    bus.miss_cnt <= bus.miss_cnt + 1'b1;
                end
            end else if (bus.resp_ready) begin
                bus.resp_valid <= 1'b0;
            end
        end
    end
endmodule
